// File: rtl/button_conditioner_if.sv
// Button bus between the raw pushbutton pins and the game core.
// The conditioner sits on the slave side. The core and pin logic sit on the master side.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = 4
);
    logic               clear;
    logic [NUM_BTN-1:0] button_raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] released;
    logic [NUM_BTN-1:0] repeat_p;
    logic               any_pressed;

    modport master (
        output clear,
        output button_raw,
        input  level,
        input  pressed,
        input  released,
        input  repeat_p,
        input  any_pressed
    );

    modport slave (
        input  clear,
        input  button_raw,
        output level,
        output pressed,
        output released,
        output repeat_p,
        output any_pressed
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debounce filter and edge/hold-repeat pulse generator.
// Every channel is independent. All outputs are registered.
module button_conditioner #(
    parameter int unsigned NUM_BTN       = 4,
    parameter int unsigned DB_LIMIT      = 50000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned REPEAT_DELAY  = 40000,
    parameter int unsigned REPEAT_PERIOD = 10000,
    parameter int unsigned REPEAT_EN     = 1
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave btn
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_LIMIT - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             REP_ON   = (REPEAT_EN != 0);

    logic [NUM_BTN-1:0] press_next;
    logic               any_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        logic             s1, s2;
        logic             lvl_q, prs_q, rel_q, rep_q;
        logic [CNT_W-1:0] db_q, rc_q;
        logic             lvl_d, prs_d, rel_d, rep_d;
        logic [CNT_W-1:0] db_d, rc_d;

        always_comb begin
            lvl_d = lvl_q;
            prs_d = 1'b0;
            rel_d = 1'b0;
            rep_d = 1'b0;
            db_d  = db_q;
            rc_d  = rc_q;
            if (btn.clear) begin
                // Adopt the synchronized level silently and restart the repeat delay.
                lvl_d = s2;
                db_d  = '0;
                rc_d  = DLY_LOAD;
            end else if (s2 != lvl_q && db_q == DB_LAST) begin
                lvl_d = s2;
                db_d  = '0;
                prs_d = s2;
                rel_d = ~s2;
                rc_d  = s2 ? DLY_LOAD : '0;
            end else begin
                db_d = (s2 == lvl_q) ? '0 : db_q + 1'b1;
                // The accepted-change branch above has priority, so a repeat never lands on a press or release.
                if (!lvl_q) begin
                    rc_d = '0;
                end else if (rc_q != '0) begin
                    rc_d = rc_q - 1'b1;
                end else begin
                    rep_d = REP_ON;
                    rc_d  = PER_LOAD;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                rep_q <= 1'b0;
                db_q  <= '0;
                rc_q  <= '0;
            end else begin
                s1    <= btn.button_raw[g];
                s2    <= s1;
                lvl_q <= lvl_d;
                prs_q <= prs_d;
                rel_q <= rel_d;
                rep_q <= rep_d;
                db_q  <= db_d;
                rc_q  <= rc_d;
            end
        end

        assign btn.level[g]    = lvl_q;
        assign btn.pressed[g]  = prs_q;
        assign btn.released[g] = rel_q;
        assign btn.repeat_p[g] = rep_q;
        assign press_next[g]   = prs_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |press_next;
        end
    end

    assign btn.any_pressed = any_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: one repeat-enabled DUT and one repeat-disabled DUT.
// Both DUTs share the same stimulus.
module tb_button_conditioner;
    localparam int unsigned NB  = 4;
    localparam int unsigned DB  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;
    localparam int unsigned LAT = DB + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [NB-1:0] raw;

    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(NB)) bus1 ();
    button_conditioner_if #(.NUM_BTN(NB)) bus2 ();

    assign bus1.clear      = clear;
    assign bus1.button_raw = raw;
    assign bus2.clear      = clear;
    assign bus2.button_raw = raw;

    button_conditioner #(
        .NUM_BTN(NB), .DB_LIMIT(DB), .CNT_W(CW),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
    ) u_dut (.clk(clk), .rst(rst), .btn(bus1));

    button_conditioner #(
        .NUM_BTN(NB), .DB_LIMIT(DB), .CNT_W(CW),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)
    ) u_dut_norep (.clk(clk), .rst(rst), .btn(bus2));

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned   at;
        logic [NB-1:0] pr, rl, rp, lvl;
    } ev_t;

    ev_t q1[$];
    ev_t q2[$];
    int  checks   = 0;
    int  failures = 0;

    // The second DUT gets the same events, except pure repeats. It must never repeat.
    function automatic void expect_ev(int unsigned at, logic [NB-1:0] pr, logic [NB-1:0] rl,
                                      logic [NB-1:0] rp, logic [NB-1:0] lvl);
        ev_t e;
        e.at = at; e.pr = pr; e.rl = rl; e.rp = rp; e.lvl = lvl;
        q1.push_back(e);
        if ((pr | rl) != '0) begin
            e.rp = '0;
            q2.push_back(e);
        end
    endfunction

    function automatic void score(int sel, logic [NB-1:0] pr, logic [NB-1:0] rl,
                                  logic [NB-1:0] rp, logic [NB-1:0] lvl, logic any);
        ev_t e;
        checks++;
        if ((sel == 1) ? (q1.size() == 0) : (q2.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_pulse dut%0d edge=%0d got pr=%b rl=%b rp=%b any=%b lvl=%b, none expected",
                     sel, edge_n, pr, rl, rp, any, lvl);
            return;
        end
        e = (sel == 1) ? q1.pop_front() : q2.pop_front();
        if (e.at != edge_n || pr !== e.pr || rl !== e.rl || rp !== e.rp || lvl !== e.lvl || any !== (|e.pr)) begin
            failures++;
            $display("FAIL pulse_event dut%0d got edge=%0d pr=%b rl=%b rp=%b any=%b lvl=%b, expected edge=%0d pr=%b rl=%b rp=%b any=%b lvl=%b",
                     sel, edge_n, pr, rl, rp, any, lvl, e.at, e.pr, e.rl, e.rp, |e.pr, e.lvl);
        end
    endfunction

    function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if ((bus1.pressed | bus1.released | bus1.repeat_p) != '0 || bus1.any_pressed)
            score(1, bus1.pressed, bus1.released, bus1.repeat_p, bus1.level, bus1.any_pressed);
        if ((bus2.pressed | bus2.released | bus2.repeat_p) != '0 || bus2.any_pressed)
            score(2, bus2.pressed, bus2.released, bus2.repeat_p, bus2.level, bus2.any_pressed);
    end

    task automatic wait_to(int unsigned t);
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic check_all_zero(string name);
        check_eq(name, 32'({bus1.level, bus1.pressed, bus1.released, bus1.repeat_p, bus1.any_pressed}), 32'd0);
        check_eq({name, "_norep"},
                 32'({bus2.level, bus2.pressed, bus2.released, bus2.repeat_p, bus2.any_pressed}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout edge=%0d", edge_n);
        $fatal(1);
    end

    initial begin
        int unsigned n, p, r;
        rst = 1'b1; clear = 1'b0; raw = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean press on channel 0, released before the first repeat is due
        n = edge_n; raw[0] = 1'b1; p = n + LAT;
        expect_ev(p, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_to(p);
        check_eq("press_level", 32'(bus1.level), 32'h1);
        wait_to(p + 1);
        check_eq("press_one_cycle", 32'(bus1.pressed), 32'h0);
        raw[0] = 1'b0;
        expect_ev(p + 1 + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_to(p + 1 + LAT + 3);

        // Bounce on channel 1: 1,0,1,0 then steady 1
        n = edge_n; raw[1] = 1'b1;
        @(negedge clk); raw[1] = 1'b0;
        @(negedge clk); raw[1] = 1'b1;
        @(negedge clk); raw[1] = 1'b0;
        @(negedge clk); raw[1] = 1'b1;
        expect_ev(n + 4 + LAT, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        wait_to(n + 11); raw[1] = 1'b0;
        expect_ev(n + 11 + LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wait_to(n + 11 + LAT + 3);

        // Hold-repeat on channel 2; the release lands where the next repeat would be due
        n = edge_n; raw[2] = 1'b1; p = n + LAT;
        expect_ev(p, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        for (int unsigned k = RD; k <= 28; k += RP)
            expect_ev(p + k, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        wait_to(p + 25); raw[2] = 1'b0;
        expect_ev(p + 31, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_to(p + 36);

        // Clear while channel 3 is held: no new press, and the repeat delay restarts
        n = edge_n; raw[3] = 1'b1; p = n + LAT;
        expect_ev(p, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        wait_to(p + 4); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_eq("clear_held_level", 32'(bus1.level), 32'h8);
        check_eq("clear_held_no_pulse", 32'({bus1.pressed, bus1.repeat_p}), 32'h0);
        for (int unsigned k = 15; k <= 21; k += RP)
            expect_ev(p + k, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        wait_to(p + 16); raw[3] = 1'b0;
        expect_ev(p + 22, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        wait_to(p + 25);

        // Clear with raw steady 1 but level still 0: level follows with no press
        n = edge_n; raw[0] = 1'b1;
        wait_to(n + 2); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_eq("clear_adopt_level", 32'(bus1.level), 32'h1);
        check_eq("clear_adopt_no_press", 32'({bus1.pressed, bus1.any_pressed}), 32'h0);
        raw[0] = 1'b0;
        expect_ev(n + 3 + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_to(n + 3 + LAT + 3);

        // Reset mid-debounce while channel 2 is already at level 1
        n = edge_n; raw = 4'b0100; p = n + LAT;
        expect_ev(p, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        wait_to(p); raw = 4'b0110;
        wait_to(p + 4); rst = 1'b1;
        wait_to(p + 5);
        check_all_zero("reset_mid_debounce");
        wait_to(p + 6); rst = 1'b0; r = edge_n;
        expect_ev(r + LAT, 4'b0110, 4'b0000, 4'b0000, 4'b0110);
        wait_to(r + LAT + 1); raw = 4'b0000;
        expect_ev(r + 1 + 2 * LAT, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
        wait_to(r + 1 + 2 * LAT + 3);

        // All four buttons together, held long enough for a run of repeats
        n = edge_n; raw = 4'b1111; p = n + LAT;
        expect_ev(p, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        for (int unsigned k = RD; k <= 55; k += RP)
            expect_ev(p + k, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
        wait_to(p + 1);
        check_eq("multi_level_norep", 32'(bus2.level), 32'hF);
        wait_to(p + 50); raw = 4'b0000;
        expect_ev(p + 56, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        wait_to(p + 62);

        check_eq("missing_events_dut1", 32'(q1.size()), 32'd0);
        check_eq("missing_events_dut2", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
